// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake bundle between an instruction source and alu_issue_ctrl.
interface alu_issue_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_inst;
    logic [DATA_WIDTH-1:0] in_rs;
    logic [DATA_WIDTH-1:0] in_rt;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_result;
    logic                  out_zero;
    logic [4:0]            out_dst;
    logic                  out_wen;

    modport master (
        output in_valid, in_inst, in_rs, in_rt, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_dst, out_wen
    );

    modport slave (
        input  in_valid, in_inst, in_rs, in_rt, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_dst, out_wen
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/decode front end for a combinational 32-bit ALU: decodes one MIPS ALU
// instruction, drives the ALU for one cycle and returns a write-back response.
module alu_issue_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          TRAP_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_issue_ctrl_if.slave       bus,
    output logic [DATA_WIDTH-1:0] alu_A,
    output logic [DATA_WIDTH-1:0] alu_B,
    output logic [2:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] alu_Result,
    input  logic                  alu_Overflow,
    input  logic                  alu_Zero,
    output logic                  ov_trap,
    output logic                  illegal
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SLTU = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t                r_state;
    logic                  r_in_ready;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [2:0]            r_op;
    logic [4:0]            r_dst;
    logic                  r_chk;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_zero;
    logic                  r_wen;
    logic                  r_trap;
    logic                  r_illegal;

    logic [5:0]            w_opcode;
    logic [5:0]            w_funct;
    logic [DATA_WIDTH-1:0] w_imm_s;
    logic [DATA_WIDTH-1:0] w_imm_z;
    logic                  w_legal;
    logic [2:0]            w_op;
    logic [DATA_WIDTH-1:0] w_b;
    logic [4:0]            w_dst;
    logic                  w_chk;
    logic                  w_trap;
    logic                  w_unused_shamt;

    assign w_opcode       = bus.in_inst[31:26];
    assign w_funct        = bus.in_inst[5:0];
    assign w_imm_s        = {{(DATA_WIDTH-16){bus.in_inst[15]}}, bus.in_inst[15:0]};
    assign w_imm_z        = DATA_WIDTH'(bus.in_inst[15:0]);
    assign w_unused_shamt = ^bus.in_inst[10:6];

    // Instruction decode: ALUop, operand B, destination and trap-check selection
    always_comb begin
        w_legal = 1'b1;
        w_op    = OP_AND;
        w_b     = bus.in_rt;
        w_dst   = bus.in_inst[15:11];
        w_chk   = 1'b0;
        if (w_opcode == 6'b000000) begin
            case (w_funct)
                6'b100000: begin w_op = OP_ADD; w_chk = 1'b1; end
                6'b100001: w_op = OP_ADD;
                6'b100010: begin w_op = OP_SUB; w_chk = 1'b1; end
                6'b100011: w_op = OP_SUB;
                6'b100100: w_op = OP_AND;
                6'b100101: w_op = OP_OR;
                6'b100110: w_op = OP_XOR;
                6'b100111: w_op = OP_NOR;
                6'b101010: w_op = OP_SLT;
                6'b101011: w_op = OP_SLTU;
                default:   w_legal = 1'b0;
            endcase
        end else begin
            w_dst = bus.in_inst[20:16];
            case (w_opcode)
                6'b001000: begin w_op = OP_ADD;  w_b = w_imm_s; w_chk = 1'b1; end
                6'b001001: begin w_op = OP_ADD;  w_b = w_imm_s; end
                6'b001010: begin w_op = OP_SLT;  w_b = w_imm_s; end
                6'b001011: begin w_op = OP_SLTU; w_b = w_imm_s; end
                6'b001100: begin w_op = OP_AND;  w_b = w_imm_z; end
                6'b001101: begin w_op = OP_OR;   w_b = w_imm_z; end
                6'b001110: begin w_op = OP_XOR;  w_b = w_imm_z; end
                default:   w_legal = 1'b0;
            endcase
        end
    end

    assign w_trap = TRAP_EN & r_chk & alu_Overflow;

    // Issue FSM; in_ready rises on the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_dst       <= '0;
            r_chk       <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_wen       <= 1'b0;
            r_trap      <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (bus.in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        r_dst      <= w_dst;
                        r_chk      <= w_chk;
                        if (w_legal) begin
                            r_a     <= bus.in_rs;
                            r_b     <= w_b;
                            r_op    <= w_op;
                            r_state <= EXEC;
                        end else begin
                            r_illegal   <= 1'b1;
                            r_result    <= '0;
                            r_zero      <= 1'b0;
                            r_wen       <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                end
                EXEC: begin
                    r_result    <= alu_Result;
                    r_zero      <= alu_Zero;
                    r_trap      <= w_trap;
                    r_wen       <= ~w_trap & (r_dst != 5'd0);
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_trap      <= 1'b0;
                        r_illegal   <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_result;
    assign bus.out_zero   = r_zero;
    assign bus.out_dst    = r_dst;
    assign bus.out_wen    = r_wen;
    assign alu_A          = r_a;
    assign alu_B          = r_b;
    assign alu_op         = r_op;
    assign ov_trap        = r_trap;
    assign illegal        = r_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed vector table, reset abort and
// randomized instructions against a mnemonic-level reference model.
module tb_alu_issue_ctrl;

    localparam int unsigned DW      = 32;
    localparam bit          TRAP_EN = 1'b1;
    localparam longint      S_MAX   = 2147483647;
    localparam longint      S_MIN   = -S_MAX - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] alu_A, alu_B, alu_Result;
    logic [2:0]    alu_op;
    logic          alu_Overflow, alu_Zero, ov_trap, illegal;

    alu_issue_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    alu_issue_ctrl #(.DATA_WIDTH(DW), .TRAP_EN(TRAP_EN)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
        .alu_Result(alu_Result), .alu_Overflow(alu_Overflow), .alu_Zero(alu_Zero),
        .ov_trap(ov_trap), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Stand-in for the external combinational ALU
    always_comb begin
        alu_Result   = '0;
        alu_Overflow = 1'b0;
        case (alu_op)
            3'b000: alu_Result = alu_A & alu_B;
            3'b001: alu_Result = alu_A | alu_B;
            3'b010: begin
                alu_Result   = alu_A + alu_B;
                alu_Overflow = (alu_A[31] == alu_B[31]) && (alu_Result[31] != alu_A[31]);
            end
            3'b011: alu_Result = DW'(alu_A < alu_B);
            3'b100: alu_Result = alu_A ^ alu_B;
            3'b101: alu_Result = ~(alu_A | alu_B);
            3'b110: begin
                alu_Result   = alu_A - alu_B;
                alu_Overflow = (alu_A[31] != alu_B[31]) && (alu_Result[31] != alu_A[31]);
            end
            default: alu_Result = DW'($signed(alu_A) < $signed(alu_B));
        endcase
        alu_Zero = (alu_Result == '0);
    end

    typedef struct packed {
        logic          legal;
        logic [2:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [4:0]    dst;
        logic [DW-1:0] result;
        logic          zero;
        logic          trap;
        logic          wen;
    } exp_t;

    typedef struct packed {
        logic [31:0]   inst;
        logic [DW-1:0] rs;
        logic [DW-1:0] rt;
        logic [3:0]    hold;
        logic [DW-1:0] res;
        logic          trap;
        logic          wen;
        logic          ill;
    } vec_t;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [2:0]    last_op  = '0;
    logic [DW-1:0] last_a   = '0;
    logic [DW-1:0] last_b   = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, 5'd1, 5'd2, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] opc, input logic [15:0] imm);
        return {opc, 5'd1, 5'd4, imm};
    endfunction

    // Reference: expected outcome computed directly from the instruction's meaning
    function automatic exp_t model(input logic [31:0] inst, input logic [DW-1:0] rs,
                                   input logic [DW-1:0] rt);
        exp_t   e;
        longint s;
        logic   chk_ov;
        logic [DW-1:0] imm_s, imm_z;
        imm_s   = {{16{inst[15]}}, inst[15:0]};
        imm_z   = {16'd0, inst[15:0]};
        e       = '0;
        e.legal = 1'b1;
        e.a     = rs;
        chk_ov  = 1'b0;
        s       = 0;
        if (inst[31:26] == 6'd0) begin
            e.dst = inst[15:11];
            e.b   = rt;
            case (inst[5:0])
                6'h20: begin e.op = 3'b010; e.result = rs + rt; chk_ov = 1'b1;
                             s = longint'($signed(rs)) + longint'($signed(rt)); end
                6'h21: begin e.op = 3'b010; e.result = rs + rt; end
                6'h22: begin e.op = 3'b110; e.result = rs - rt; chk_ov = 1'b1;
                             s = longint'($signed(rs)) - longint'($signed(rt)); end
                6'h23: begin e.op = 3'b110; e.result = rs - rt; end
                6'h24: begin e.op = 3'b000; e.result = rs & rt; end
                6'h25: begin e.op = 3'b001; e.result = rs | rt; end
                6'h26: begin e.op = 3'b100; e.result = rs ^ rt; end
                6'h27: begin e.op = 3'b101; e.result = ~(rs | rt); end
                6'h2A: begin e.op = 3'b111; e.result = DW'($signed(rs) < $signed(rt)); end
                6'h2B: begin e.op = 3'b011; e.result = DW'(rs < rt); end
                default: e.legal = 1'b0;
            endcase
        end else begin
            e.dst = inst[20:16];
            case (inst[31:26])
                6'h08: begin e.op = 3'b010; e.b = imm_s; e.result = rs + imm_s; chk_ov = 1'b1;
                             s = longint'($signed(rs)) + longint'($signed(imm_s)); end
                6'h09: begin e.op = 3'b010; e.b = imm_s; e.result = rs + imm_s; end
                6'h0A: begin e.op = 3'b111; e.b = imm_s;
                             e.result = DW'($signed(rs) < $signed(imm_s)); end
                6'h0B: begin e.op = 3'b011; e.b = imm_s; e.result = DW'(rs < imm_s); end
                6'h0C: begin e.op = 3'b000; e.b = imm_z; e.result = rs & imm_z; end
                6'h0D: begin e.op = 3'b001; e.b = imm_z; e.result = rs | imm_z; end
                6'h0E: begin e.op = 3'b100; e.b = imm_z; e.result = rs ^ imm_z; end
                default: e.legal = 1'b0;
            endcase
        end
        if (!e.legal) e.result = '0;
        e.zero = e.legal && (e.result == '0);
        e.trap = TRAP_EN && chk_ov && ((s > S_MAX) || (s < S_MIN));
        e.wen  = e.legal && !e.trap && (e.dst != 5'd0);
        return e;
    endfunction

    // Issue one instruction, follow it to its response and retire it
    task automatic issue(input logic [31:0] inst, input logic [DW-1:0] rs,
                         input logic [DW-1:0] rt, input int hold, input bit noise,
                         input exp_t e);
        int n;
        logic [DW-1:0] held;
        @(negedge clk);
        n = 0;
        while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
        chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_rs    = rs;
        bus.in_rt    = rt;
        @(posedge clk); #1;
        bus.in_valid = noise;
        bus.in_inst  = $urandom;
        bus.in_rs    = $urandom;
        chk("in_ready_busy", 64'(bus.in_ready), 64'd0);
        n = 1;
        while (!bus.out_valid && n < 10) begin @(posedge clk); #1; n++; end
        chk("latency", 64'(n), e.legal ? 64'd2 : 64'd1);
        if (e.legal) begin
            last_op = e.op; last_a = e.a; last_b = e.b;
        end
        chk("alu_op", 64'(alu_op), 64'(last_op));
        chk("alu_A", 64'(alu_A), 64'(last_a));
        chk("alu_B", 64'(alu_B), 64'(last_b));
        chk("out_result", 64'(bus.out_result), 64'(e.result));
        chk("out_wen", 64'(bus.out_wen), 64'(e.wen));
        chk("ov_trap", 64'(ov_trap), 64'(e.trap));
        chk("illegal", 64'(illegal), 64'(!e.legal));
        if (e.legal) begin
            chk("out_zero", 64'(bus.out_zero), 64'(e.zero));
            chk("out_dst", 64'(bus.out_dst), 64'(e.dst));
        end
        held = bus.out_result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_ready", 64'(bus.in_ready), 64'd0);
            chk("hold_result", 64'(bus.out_result), 64'(held));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("retire_valid", 64'(bus.out_valid), 64'd0);
        chk("retire_trap", 64'(ov_trap), 64'd0);
        chk("retire_illegal", 64'(illegal), 64'd0);
        chk("retire_ready", 64'(bus.in_ready), 64'd1);
    endtask

    vec_t tbl [12];
    logic [31:0] legal_enc [17];

    initial begin
        exp_t e;
        logic [31:0] inst;
        logic [DW-1:0] rs, rt;
        int n;

        tbl[0]  = '{rtype(5'd3, 6'h20), 32'h7FFFFFFF, 32'h1, 4'd5, 32'h80000000, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{rtype(5'd3, 6'h21), 32'h7FFFFFFF, 32'h1, 4'd0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{itype(6'h0A, 16'hFFFF), 32'hFFFFFFFE, 32'h0, 4'd0, 32'h1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{itype(6'h0B, 16'hFFFF), 32'hFFFFFFFE, 32'h0, 4'd1, 32'h1, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{itype(6'h0C, 16'h8000), 32'hFFFF1234, 32'h0, 4'd0, 32'h0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{itype(6'h0E, 16'h0000), 32'hFFFF1234, 32'h0, 4'd0, 32'hFFFF1234, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{itype(6'h3F, 16'h1234), 32'h11111111, 32'h2, 4'd2, 32'h0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{rtype(5'd0, 6'h23), 32'h5, 32'h7, 4'd5, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{rtype(5'd9, 6'h22), 32'h80000000, 32'h1, 4'd0, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{rtype(5'd7, 6'h27), 32'h0, 32'h0, 4'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{itype(6'h08, 16'h0001), 32'h7FFFFFFF, 32'h0, 4'd0, 32'h80000000, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{rtype(5'd5, 6'h00), 32'h3, 32'h4, 4'd1, 32'h0, 1'b0, 1'b0, 1'b1};

        legal_enc = '{rtype(5'd0, 6'h20), rtype(5'd0, 6'h21), rtype(5'd0, 6'h22),
                      rtype(5'd0, 6'h23), rtype(5'd0, 6'h24), rtype(5'd0, 6'h25),
                      rtype(5'd0, 6'h26), rtype(5'd0, 6'h27), rtype(5'd0, 6'h2A),
                      rtype(5'd0, 6'h2B), itype(6'h08, 16'h0), itype(6'h09, 16'h0),
                      itype(6'h0A, 16'h0), itype(6'h0B, 16'h0), itype(6'h0C, 16'h0),
                      itype(6'h0D, 16'h0), itype(6'h0E, 16'h0)};

        bus.in_valid  = 1'b0;
        bus.in_inst   = '0;
        bus.in_rs     = '0;
        bus.in_rt     = '0;
        bus.out_ready = 1'b0;

        #12;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_alu_op", 64'(alu_op), 64'd0);
        chk("rst_alu_A", 64'(alu_A), 64'd0);
        chk("rst_out_result", 64'(bus.out_result), 64'd0);
        chk("rst_flags", 64'({ov_trap, illegal, bus.out_wen}), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

        for (int i = 0; i < 12; i++) begin
            e = model(tbl[i].inst, tbl[i].rs, tbl[i].rt);
            e.result = tbl[i].res;
            e.trap   = tbl[i].trap;
            e.wen    = tbl[i].wen;
            e.legal  = !tbl[i].ill;
            issue(tbl[i].inst, tbl[i].rs, tbl[i].rt, int'(tbl[i].hold), 1'b0, e);
        end

        // Reset during EXEC aborts the operation without a response
        @(negedge clk);
        n = 0;
        while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
        bus.in_valid = 1'b1;
        bus.in_inst  = rtype(5'd6, 6'h21);
        bus.in_rs    = 32'h10;
        bus.in_rt    = 32'h20;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("exec_alu_op", 64'(alu_op), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_alu_op", 64'(alu_op), 64'd0);
        chk("abort_alu_A", 64'(alu_A), 64'd0);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        last_op = '0; last_a = '0; last_b = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("abort_no_resp", 64'(bus.out_valid), 64'd0);
        end
        chk("abort_idle_ready", 64'(bus.in_ready), 64'd1);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) inst = $urandom;
            else begin
                inst = legal_enc[$urandom_range(0, 16)];
                inst[25:6] = 20'($urandom);
            end
            case ($urandom_range(0, 3))
                0: rs = 32'h7FFFFFFF;
                1: rs = 32'h80000000;
                default: rs = $urandom;
            endcase
            rt = ($urandom_range(0, 3) == 0) ? 32'(rs) : 32'($urandom);
            if ($urandom_range(0, 4) == 0) inst[15:0] = 16'($urandom_range(0, 1));
            e = model(inst, rs, rt);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(inst, rs, rt, $urandom_range(0, 3), 1'($urandom_range(0, 1)), e);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
